// File: rtl/vga_sync_gen.sv
// 640x480 raster timing generator: pixel-rate strobe, h/v counters and registered
// sync/visible flags aligned with the coordinates they describe.
module vga_sync_gen #(
   parameter int CLK_DIV  = 4,
   parameter int H_VIS    = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_VIS    = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic       CLKIN,
   input  logic       RESET,
   output logic       HSYNC,
   output logic       VSYNC,
   output logic       VIDEO_ON,
   output logic       PIXELTICK,
   output logic [9:0] PIXEL_X,
   output logic [9:0] PIXEL_Y,
   output logic       LINE_START,
   output logic       FRAME_START
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

   function automatic logic in_window(input logic [9:0] c, input int lo, input int hi);
      return (int'(c) >= lo) && (int'(c) < hi);
   endfunction

   function automatic logic sync_level(input logic active);
      return active ? SYNC_POL : ~SYNC_POL;
   endfunction

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_nxt;
   logic [9:0]       h_cnt;
   logic [9:0]       v_cnt;
   logic [9:0]       h_nxt;
   logic [9:0]       v_nxt;
   logic             tick;
   logic             h_wrap;
   logic             hsync_r;
   logic             vsync_r;
   logic             video_r;
   logic             x_zero;
   logic             y_zero;

   // next-state counters; flags below are derived from these so they land with the coordinates
   always_comb begin
      tick    = (div_cnt == DIV_LAST);
      h_wrap  = tick && (h_cnt == H_LAST);
      div_nxt = tick ? '0 : div_cnt + 1'b1;
      h_nxt   = h_cnt;
      v_nxt   = v_cnt;
      if (tick) begin
         h_nxt = h_wrap ? 10'd0 : h_cnt + 10'd1;
      end
      if (h_wrap) begin
         v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end
   end

   always_ff @(posedge CLKIN) begin
      if (RESET) begin
         div_cnt <= '0;
         h_cnt   <= '0;
         v_cnt   <= '0;
         hsync_r <= ~SYNC_POL;
         vsync_r <= ~SYNC_POL;
         video_r <= 1'b0;
         x_zero  <= 1'b1;
         y_zero  <= 1'b1;
      end else begin
         div_cnt <= div_nxt;
         h_cnt   <= h_nxt;
         v_cnt   <= v_nxt;
         hsync_r <= sync_level(in_window(h_nxt, H_VIS + H_FP, H_VIS + H_FP + H_SYNC));
         vsync_r <= sync_level(in_window(v_nxt, V_VIS + V_FP, V_VIS + V_FP + V_SYNC));
         video_r <= in_window(h_nxt, 0, H_VIS) && in_window(v_nxt, 0, V_VIS);
         x_zero  <= (h_nxt == 10'd0);
         y_zero  <= (v_nxt == 10'd0);
      end
   end

   assign PIXELTICK   = tick;
   assign PIXEL_X     = h_cnt;
   assign PIXEL_Y     = v_cnt;
   assign HSYNC       = hsync_r;
   assign VSYNC       = vsync_r;
   assign VIDEO_ON    = video_r;
   assign LINE_START  = tick & x_zero;
   assign FRAME_START = tick & x_zero & y_zero;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a full-size 640x480 instance for startup, cadence and
// line timing, plus a shrunken instance (CLK_DIV=2, active-high sync) for frame timing and reset.
module tb_vga_sync_gen;

   localparam int H_TOT0 = 640 + 16 + 96 + 48;
   localparam int V_TOT0 = 480 + 10 + 2 + 33;

   logic       clk = 1'b0;
   logic       rst0, rst1;
   logic       hs0, vs0, von0, tk0, ls0, fs0;
   logic       hs1, vs1, von1, tk1, ls1, fs1;
   logic [9:0] x0, y0, x1, y1;

   int    total   = 0;
   int    passed  = 0;
   int    cur_cyc = 0;
   string cur_who = "";

   always #5 clk = ~clk;

   vga_sync_gen #(
      .CLK_DIV(4), .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_VIS(480), .V_FP(10), .V_SYNC(2), .V_BP(33), .SYNC_POL(1'b0)
   ) d0 (
      .CLKIN(clk), .RESET(rst0), .HSYNC(hs0), .VSYNC(vs0), .VIDEO_ON(von0),
      .PIXELTICK(tk0), .PIXEL_X(x0), .PIXEL_Y(y0), .LINE_START(ls0), .FRAME_START(fs0)
   );

   // 15 x 9 raster: hsync on x 10..12, vsync on y 6..7, 270 clocks per frame
   vga_sync_gen #(
      .CLK_DIV(2), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_VIS(4), .V_FP(2), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
   ) d1 (
      .CLKIN(clk), .RESET(rst1), .HSYNC(hs1), .VSYNC(vs1), .VIDEO_ON(von1),
      .PIXELTICK(tk1), .PIXEL_X(x1), .PIXEL_Y(y1), .LINE_START(ls1), .FRAME_START(fs1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s.%s cyc=%0d: observed %0d expected %0d", cur_who, tag, cur_cyc, obs, exp);
   endtask

   // c = rising edges since reset release; the raster position follows from it directly
   task automatic check_frame(input int c, input int div, input int ht, input int vt,
                              input int hvis, input int vvis, input int hs_lo, input int hs_hi,
                              input int vs_lo, input int vs_hi, input logic pol,
                              input logic hs, input logic vs, input logic von, input logic tk,
                              input logic ls, input logic fs, input logic [9:0] x,
                              input logic [9:0] y);
      int   pix, ex, ey;
      logic etk, ehs, evs, evon;
      pix  = c / div;
      ex   = pix % ht;
      ey   = (pix / ht) % vt;
      etk  = (c % div) == (div - 1);
      ehs  = (ex >= hs_lo && ex < hs_hi) ? pol : ~pol;
      evs  = (ey >= vs_lo && ey < vs_hi) ? pol : ~pol;
      evon = (ex < hvis) && (ey < vvis);
      cur_cyc = c;
      chk("x", 32'(x), 32'(ex));
      chk("y", 32'(y), 32'(ey));
      chk("tick", 32'(tk), 32'(etk));
      chk("hsync", 32'(hs), 32'(ehs));
      chk("vsync", 32'(vs), 32'(evs));
      chk("video_on", 32'(von), 32'(evon));
      chk("line_start", 32'(ls), 32'(etk && ex == 0));
      chk("frame_start", 32'(fs), 32'(etk && ex == 0 && ey == 0));
   endtask

   task automatic chk0(input int c);
      cur_who = "d0";
      check_frame(c, 4, 800, 525, 640, 480, 656, 752, 490, 492, 1'b0,
                  hs0, vs0, von0, tk0, ls0, fs0, x0, y0);
   endtask

   task automatic chk1(input int c);
      cur_who = "d1";
      check_frame(c, 2, 15, 9, 8, 4, 10, 13, 6, 8, 1'b1,
                  hs1, vs1, von1, tk1, ls1, fs1, x1, y1);
   endtask

   initial begin
      int   ticks, hs_low, last_fs, lines, n_fs, c, n;
      logic prev_tk;

      if (H_TOT0 > 1024 || V_TOT0 > 1024) begin
         $display("FAIL geometry: totals %0d x %0d exceed 10-bit counters", H_TOT0, V_TOT0);
         $fatal(1);
      end

      // reset held for 5 clocks
      rst0 = 1'b1;
      rst1 = 1'b1;
      repeat (5) step();
      cur_who = "d0";
      chk("rst_x", 32'(x0), 0);
      chk("rst_y", 32'(y0), 0);
      chk("rst_hsync", 32'(hs0), 1);
      chk("rst_vsync", 32'(vs0), 1);
      chk("rst_video_on", 32'(von0), 0);
      chk("rst_tick", 32'(tk0), 0);
      chk("rst_line_start", 32'(ls0), 0);
      chk("rst_frame_start", 32'(fs0), 0);
      cur_who = "d1";
      chk("rst_hsync", 32'(hs1), 0);
      chk("rst_vsync", 32'(vs1), 0);
      chk("rst_tick", 32'(tk1), 0);

      // startup: first tick and frame start on the 3rd clock after release
      rst0 = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk0(i);
      end
      cur_who = "d0";
      chk("first_tick", 32'(tk0), 1);
      chk("first_frame_start", 32'(fs0), 1);
      chk("first_line_start", 32'(ls0), 1);
      chk("first_video_on", 32'(von0), 1);

      // tick cadence over 40 clocks
      ticks   = 0;
      prev_tk = tk0;
      for (int i = 4; i <= 43; i++) begin
         step();
         chk0(i);
         chk("double_tick", 32'(tk0 & prev_tk), 0);
         if (tk0) ticks++;
         prev_tk = tk0;
      end
      cur_who = "d0";
      chk("ticks_in_40", 32'(ticks), 10);

      // one full line plus the wrap into line 1
      hs_low = 0;
      for (int i = 44; i <= 3210; i++) begin
         step();
         chk0(i);
         if (hs0 == 1'b0) hs_low++;
         if (i == 2560) chk("video_off_at_640", 32'(von0), 0);
         if (i == 3200) begin
            chk("wrap_x", 32'(x0), 0);
            chk("wrap_y", 32'(y0), 1);
         end
      end
      cur_who = "d0";
      chk("hsync_low_clocks", 32'(hs_low), 384);

      // small raster: two full frames
      rst1    = 1'b0;
      last_fs = -1;
      lines   = 0;
      n_fs    = 0;
      c       = 0;
      for (int i = 1; i <= 545; i++) begin
         step();
         c = i;
         chk1(c);
         if (ls1) lines++;
         if (fs1) begin
            n_fs++;
            if (last_fs >= 0) begin
               chk("frame_period", 32'(c - last_fs), 270);
               chk("lines_per_frame", 32'(lines - 1), 9);
            end
            last_fs = c;
            lines   = 1;
         end
      end
      cur_who = "d1";
      chk("frame_starts", 32'(n_fs), 3);

      // run to x=11, y=3 (inside hsync) and reset for one clock
      n = 0;
      while (!(x1 == 10'd11 && y1 == 10'd3) && n < 600) begin
         step();
         c++;
         n++;
         chk1(c);
      end
      cur_who = "d1";
      chk("reach_midframe", 32'(n < 600), 1);
      chk("mid_hsync_active", 32'(hs1), 1);
      rst1 = 1'b1;
      step();
      chk("mid_rst_hsync", 32'(hs1), 0);
      chk("mid_rst_x", 32'(x1), 0);
      chk("mid_rst_y", 32'(y1), 0);
      chk("mid_rst_video_on", 32'(von1), 0);
      chk("mid_rst_tick", 32'(tk1), 0);
      rst1 = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         step();
         chk1(i);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator that sits directly upstream of the pixel-generation stage and the top-level RGB output register.
- Divides the system clock down to a one-cycle pixel strobe and runs horizontal and vertical counters across the full 640x480 frame.
- Drives registered HSYNC/VSYNC, the visible-area flag, the current pixel coordinates, and line/frame start strobes.
- Downstream logic consumes PIXEL_X/PIXEL_Y/VIDEO_ON and samples its colour output on PIXELTICK.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal range >= 2.
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_VIS, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_POL, 0, active level of HSYNC and VSYNC (0 = active-low).

Ports:
- CLKIN  input  1  system clock, all logic on rising edge
- RESET  input  1  synchronous, active-high reset
- HSYNC  output  1  horizontal sync, registered
- VSYNC  output  1  vertical sync, registered
- VIDEO_ON  output  1  high while (PIXEL_X, PIXEL_Y) is in the visible area
- PIXELTICK  output  1  one-clock strobe, once per CLK_DIV clocks
- PIXEL_X  output  10  current horizontal count, 0..H_TOTAL-1
- PIXEL_Y  output  10  current vertical count, 0..V_TOTAL-1
- LINE_START  output  1  one-clock pulse: PIXELTICK high and PIXEL_X==0
- FRAME_START  output  1  one-clock pulse: PIXELTICK high, PIXEL_X==0 and PIXEL_Y==0

Behaviour:
- Interface: one clock CLKIN; RESET is synchronous and active-high. No other clock or reset.
- Derived constants: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525). Both must be <= 1024; the bench checks this at elaboration.
- Divider: div_cnt counts 0..CLK_DIV-1, then wraps to 0. PIXELTICK = 1 exactly in the clocks where div_cnt == CLK_DIV-1, giving period CLK_DIV and duty 1/CLK_DIV.
- Horizontal counter: advances only in a clock where PIXELTICK is high. At H_TOTAL-1 it wraps to 0.
- Vertical counter: advances in the same clock as the horizontal wrap. At V_TOTAL-1 it wraps to 0; simultaneous h and v wrap returns to (0,0).
- PIXEL_X/PIXEL_Y are the counter registers themselves. Each coordinate is held for exactly CLK_DIV clocks, ending with the PIXELTICK clock.
- HSYNC active (== SYNC_POL) when H_VIS+H_FP <= PIXEL_X < H_VIS+H_FP+H_SYNC, i.e. 656..751; otherwise inactive.
- VSYNC active when V_VIS+V_FP <= PIXEL_Y < V_VIS+V_FP+V_SYNC, i.e. 490..491.
- VIDEO_ON = (PIXEL_X < H_VIS) && (PIXEL_Y < V_VIS).
- Alignment: HSYNC, VSYNC and VIDEO_ON are registered from the next-state counter values, so they change in the same clock as PIXEL_X/PIXEL_Y. There is zero skew between coordinates and flags.
- LINE_START/FRAME_START: combinational AND of PIXELTICK with registered compares; they assert only in a PIXELTICK clock.
- Reset (while RESET=1 at an edge):
  - div_cnt=0, PIXEL_X=0, PIXEL_Y=0.
  - HSYNC=VSYNC=~SYNC_POL (inactive).
  - VIDEO_ON=0, PIXELTICK=0, LINE_START=0, FRAME_START=0.
- First edge after RESET release: div_cnt=1, coordinates stay (0,0), VIDEO_ON=1. The first PIXELTICK occurs CLK_DIV-1 clocks after release; FRAME_START asserts with it.
- Reset mid-frame: aborts immediately with no completion of the current line. The restart is identical to power-up.
- No enable input: the counters free-run whenever RESET=0.

Test Plan:
- Reset/startup: hold RESET 5 clocks -> all outputs at reset values, HSYNC=VSYNC=1. Release -> PIXELTICK first high on the 3rd clock after release, FRAME_START and LINE_START high in that same clock, VIDEO_ON=1.
- Tick cadence: run 40 clocks -> PIXELTICK high every 4th clock and never two consecutive clocks; PIXEL_X increments by 1 only after each tick.
- Line timing: observe one line -> VIDEO_ON falls when PIXEL_X becomes 640; HSYNC low for exactly 96 pixels (384 clocks) starting at PIXEL_X=656; PIXEL_X wraps 799->0 and PIXEL_Y increments in that same clock.
- Frame timing: run a full frame -> VSYNC low for PIXEL_Y 490..491 (2 lines = 6400 clocks); PIXEL_Y wraps 524->0. FRAME_START pulses repeat every 1,680,000 clocks, and LINE_START occurs 525 times between them.
- Mid-frame reset: assert RESET for 1 clock at PIXEL_X=700, PIXEL_Y=300 (HSYNC active) -> next clock HSYNC=1, coordinates (0,0), VIDEO_ON=0. Subsequent sequence identical to the startup case.
- Parameter sweep: CLK_DIV=2, SYNC_POL=1 -> PIXELTICK every 2nd clock, sync pulses active-high with the same pixel boundaries, frame period 840,000 clocks.
